requant_writeback: RTL
======================

// Module: requant_writeback
// PURPOSE
//  Downstream of the layer engine. After a layer finishes, this block reads the
//  NUM_NEURONS 2*DATA_WIDTH accumulators from the result BRAM and requantizes each one
//  (scale multiply, round-shift, optional ReLU, saturate). It writes the DATA_WIDTH
//  results into the next layer's token BRAM, so layers chain without the host.
// PARAMETERS
//  ADDR_WIDTH   10  BRAM address width (both memories)
//  DATA_WIDTH   16  token width; accumulator width is 2*DATA_WIDTH
//  NUM_NEURONS  16  entries processed per run (1..2**ADDR_WIDTH)
//  RES_BASE     0   first result-BRAM address read
//  TOK_BASE     0   first token-BRAM address written
// PORTS
//  clk           in   1             clock, all logic on rising edge
//  rst           in   1             asynchronous, active-low reset
//  start         in   1             1-cycle run request; sampled only in IDLE
//  scale         in   DATA_WIDTH    unsigned multiplier, latched on accepted start
//  shift         in   5             right-shift amount 0..31, latched on start
//  relu_en       in   1             clamp negatives to 0, latched on start
//  res_rd_en     out  1             result BRAM read enable
//  res_rd_addr   out  ADDR_WIDTH    result BRAM read address
//  res_rd_data   in   2*DATA_WIDTH  signed accumulator, valid 1 cycle after rd_en
//  tok_wr_en     out  1             token BRAM write enable
//  tok_wr_addr   out  ADDR_WIDTH    token BRAM write address
//  tok_wr_data   out  DATA_WIDTH    signed requantized value
//  busy          out  1             high from first read through last write
//  done          out  1             1-cycle pulse after last write
// BEHAVIOUR
//  - Reset (rst=0, async): FSM->IDLE; counters, pipeline valids and all outputs = 0.
//    Mid-run reset aborts immediately: no further writes and no done.
//  - FSM: IDLE -start-> READ (NUM_NEURONS cycles, one rd_en per cycle, addr
//    RES_BASE+i) -> DRAIN (until pipeline empty) -> FIN (done=1, one cycle) -> IDLE.
//  - Timing, start accepted in cycle 0: reads in cycles 1..N; data valid 2..N+1;
//    product register 3..N+2; write registers 4..N+3; done in cycle N+4.
//    busy = 1 in cycles 1..N+3. Throughput is 1 entry/cycle with no bubbles.
//  - start while not IDLE is ignored. start in the FIN cycle is ignored.
//    Config stays latched for the whole run.
//  - Write i goes to TOK_BASE+i. All addresses wrap modulo 2**ADDR_WIDTH.
//  - Arithmetic, per entry:
//    p = signed(acc) * signed({1'b0,scale}), 3*DATA_WIDTH+1 bits, exact.
//    r = (p + (shift ? 1<<(shift-1) : 0)) >>> shift, i.e. round half toward +inf.
//    If relu_en and r<0: r=0.
//    Saturate r to [-2**(DW-1), 2**(DW-1)-1].
//  - scale=0 gives all-zero outputs. shift=0 means no rounding term.
//  - tok_wr_addr/tok_wr_data are held at 0 when tok_wr_en=0.
// STRUCTURE
//  - layer_pkg: state enum {IDLE,READ,DRAIN,FIN}; ACC_W=2*DATA_WIDTH;
//    PROD_W=3*DATA_WIDTH+1; function sat_to_dw().
//  - Sub-module requant_core: 2-stage pipeline (multiply reg; round/relu/sat reg)
//    with a valid bit and address tag riding alongside. The top holds the FSM,
//    read counter and config latches.
// TESTING  (DW=16, N=16, bases 0, BRAM model with 1-cycle read latency)
//  1. acc[i]=i*100, scale=1, shift=0, relu=0 -> tok[i]=i*100.
//     Writes in cycles 4..19, done in cycle 20, busy in cycles 1..19.
//  2. acc=7, scale=3, shift=2 -> 21+2=23, >>>2 = 5.
//     acc=-7 with the same config -> -21+2=-19, >>>2 = -5.
//  3. acc=2**30, scale=4, shift=0 -> 32767. acc=-2**30 -> -32768.
//  4. relu_en=1, acc=-500, scale=1, shift=0 -> 0. acc=500 -> 500.
//  5. Pulse start again in cycles 5 and 20 of a run -> both ignored, exactly 16
//     writes. Change scale mid-run -> outputs use the latched value.
//  6. Drop rst in cycle 10 -> busy, tok_wr_en and done are 0 that cycle. No later
//     writes. A fresh start after release completes normally.

Source files
------------

// File: rtl/layer_pkg.sv
// Shared types and width helpers for the layer write-back path.
// Saturation works on a 64-bit carrier, so products of up to 64 bits are supported.
package layer_pkg;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

    function automatic int acc_w(input int dw);
        return 2 * dw;
    endfunction

    function automatic int prod_w(input int dw);
        return 3 * dw + 1;
    endfunction

    // Clamp a signed value into the range of a dw-bit two's-complement token.
    function automatic logic signed [63:0] sat_to_dw(input logic signed [63:0] v, input int dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/requant_core.sv
// Two-stage requantizer: exact scale multiply, then round/ReLU/saturate.
// A valid bit and write-address tag travel with each entry.
module requant_core
    import layer_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [ADDR_WIDTH-1:0]     in_addr,
    input  logic [2*DATA_WIDTH-1:0]   in_data,
    input  logic [DATA_WIDTH-1:0]     scale,
    input  logic [4:0]                shift,
    input  logic                      relu_en,
    output logic                      pipe_valid,
    output logic                      out_valid,
    output logic [ADDR_WIDTH-1:0]     out_addr,
    output logic [DATA_WIDTH-1:0]     out_data
);

    localparam int PROD_W = prod_w(DATA_WIDTH);

    logic signed [PROD_W-1:0]  acc_x;
    logic signed [PROD_W-1:0]  scl_x;
    logic signed [PROD_W-1:0]  prod;
    logic [ADDR_WIDTH-1:0]     pipe_addr;
    logic signed [PROD_W-1:0]  rnd;
    logic signed [PROD_W-1:0]  shifted;
    logic [DATA_WIDTH-1:0]     sat_d;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        acc_x   = PROD_W'($signed(in_data));
        scl_x   = PROD_W'({1'b0, scale});
        rnd     = '0;
        if (shift != 5'd0) rnd = PROD_W'(1) << (shift - 5'd1);
        shifted = (prod + rnd) >>> shift;
        if (relu_en && shifted < 0) shifted = '0;
        sat_d   = DATA_WIDTH'(sat_to_dw(64'(shifted), DATA_WIDTH));
    end

    // Bubbles carry zeros so the write port idles at 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_valid <= 1'b0;
            pipe_addr  <= '0;
            prod       <= '0;
            out_valid  <= 1'b0;
            out_addr   <= '0;
            out_data   <= '0;
        end else begin
            pipe_valid <= in_valid;
            pipe_addr  <= in_valid ? in_addr : '0;
            prod       <= in_valid ? acc_x * scl_x : '0;
            out_valid  <= pipe_valid;
            out_addr   <= pipe_valid ? pipe_addr : '0;
            out_data   <= pipe_valid ? sat_d : '0;
        end
    end

endmodule

// File: rtl/requant_writeback.sv
// Streams the result BRAM through the requantizer into the next layer's token BRAM.
// Holds the run FSM, read counter and the configuration latched at start.
module requant_writeback
    import layer_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_NEURONS = 16,
    parameter int RES_BASE    = 0,
    parameter int TOK_BASE    = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DATA_WIDTH-1:0]     scale,
    input  logic [4:0]                shift,
    input  logic                      relu_en,
    output logic                      res_rd_en,
    output logic [ADDR_WIDTH-1:0]     res_rd_addr,
    input  logic [2*DATA_WIDTH-1:0]   res_rd_data,
    output logic                      tok_wr_en,
    output logic [ADDR_WIDTH-1:0]     tok_wr_addr,
    output logic [DATA_WIDTH-1:0]     tok_wr_data,
    output logic                      busy,
    output logic                      done
);

    localparam logic [ADDR_WIDTH-1:0] RES_BASE_A = ADDR_WIDTH'(RES_BASE);
    localparam logic [ADDR_WIDTH-1:0] TOK_BASE_A = ADDR_WIDTH'(TOK_BASE);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(NUM_NEURONS - 1);

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  cnt;
    logic                   data_valid;
    logic [ADDR_WIDTH-1:0]  data_tag;
    logic [DATA_WIDTH-1:0]  scale_q;
    logic [4:0]             shift_q;
    logic                   relu_q;
    logic                   pipe_valid;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            res_rd_en   <= 1'b0;
            res_rd_addr <= '0;
            data_valid  <= 1'b0;
            data_tag    <= '0;
            scale_q     <= '0;
            shift_q     <= '0;
            relu_q      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            // BRAM data arrives one cycle after the read; tag it with its write address.
            data_valid <= res_rd_en;
            data_tag   <= res_rd_en ? TOK_BASE_A + cnt : '0;
            case (state)
                IDLE: if (start) begin
                    state       <= READ;
                    cnt         <= '0;
                    res_rd_en   <= 1'b1;
                    res_rd_addr <= RES_BASE_A;
                    scale_q     <= scale;
                    shift_q     <= shift;
                    relu_q      <= relu_en;
                    busy        <= 1'b1;
                end
                READ: if (cnt == LAST_IDX) begin
                    state       <= DRAIN;
                    res_rd_en   <= 1'b0;
                    res_rd_addr <= '0;
                end else begin
                    cnt         <= cnt + 1'b1;
                    res_rd_addr <= res_rd_addr + 1'b1;
                end
                // The last write is on the port and nothing is behind it.
                DRAIN: if (tok_wr_en && !pipe_valid && !data_valid) begin
                    state <= FIN;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                FIN: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    requant_core #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (data_valid),
        .in_addr    (data_tag),
        .in_data    (res_rd_data),
        .scale      (scale_q),
        .shift      (shift_q),
        .relu_en    (relu_q),
        .pipe_valid (pipe_valid),
        .out_valid  (tok_wr_en),
        .out_addr   (tok_wr_addr),
        .out_data   (tok_wr_data)
    );

endmodule
